// File: rtl/game_score_keeper.sv
// game_score_keeper: BCD score, high score, lives and credits plus the STANDBY/PLAY/GAME_OVER sequencer.
// Every output is registered (event on cycle N seen at N+1). Optional bonus life: define EXTRA_LIFE_EN.
module game_score_keeper #(
`ifdef EXTRA_LIFE_EN
    parameter int EXTRA_LIFE_SCORE = 1500,
`endif
    parameter int LIVES_INIT       = 3,
    parameter int MAX_CREDITS      = 9,
    parameter int UFO_POINTS       = 100,
    parameter int GAME_OVER_FRAMES = 180
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        alienHit,
    input  logic [1:0]  alienRow,
    input  logic        ufoHit,
    input  logic        playerHit,
    input  logic        invasion,
    input  logic        coinIn,
    input  logic        startBtn,
    output logic [15:0] scoreBCD,
    output logic [15:0] highScoreBCD,
    output logic [2:0]  lives,
    output logic [3:0]  credits,
    output logic        standBy,
    output logic        gameEnded
);

    typedef enum logic [1:0] {
        ST_STANDBY   = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0]  r;
        int unsigned  t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Per-digit decimal add; bit 16 is the carry out of the thousands digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  dsum;
        logic        carry;
        logic [15:0] r;
        carry = 1'b0;
        r     = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, carry};
            if (dsum > 5'd9) begin
                dsum  = dsum + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            r[i*4 +: 4] = dsum[3:0];
        end
        return {carry, r};
    endfunction

    localparam logic [15:0] UFO_BCD    = to_bcd(UFO_POINTS);
    localparam logic [7:0]  GO_FRAMES  = 8'(GAME_OVER_FRAMES);
    localparam logic [3:0]  CRED_MAX   = 4'(MAX_CREDITS);
    localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_INIT);
`ifdef EXTRA_LIFE_EN
    localparam logic [15:0] BONUS_BCD  = to_bcd(EXTRA_LIFE_SCORE);
`endif

    state_t      state_q,   state_d;
    logic [15:0] score_q,   score_d;
    logic [15:0] high_q,    high_d;
    logic [2:0]  lives_q,   lives_d;
    logic [3:0]  credits_q, credits_d;
    logic [7:0]  frame_q,   frame_d;
    logic        standby_q, standby_d;
    logic        ended_q,   ended_d;
`ifdef EXTRA_LIFE_EN
    logic        bonus_used_q, bonus_used_d;
`endif

    logic        start_ok;
    logic [15:0] alien_bcd;
    logic [15:0] hit_pts;
    logic [16:0] score_sum;
    logic [15:0] score_hit;
    logic [2:0]  lives_tmp;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        high_d    = high_q;
        lives_d   = lives_q;
        credits_d = credits_q;
        frame_d   = frame_q;
`ifdef EXTRA_LIFE_EN
        bonus_used_d = bonus_used_q;
`endif
        lives_tmp = lives_q;

        start_ok = (state_q == ST_STANDBY) && startBtn && (credits_q != 4'd0);

        alien_bcd = 16'h0000;
        if (alienHit) begin
            case (alienRow)
                2'd0:    alien_bcd = 16'h0010;
                2'd1:    alien_bcd = 16'h0020;
                default: alien_bcd = 16'h0030;
            endcase
        end
        // Alien plus UFO points never exceed three digits, so the carry is always clear.
        hit_pts   = 16'(bcd_add(alien_bcd, ufoHit ? UFO_BCD : 16'h0000));
        score_sum = bcd_add(score_q, hit_pts);
        score_hit = score_sum[16] ? 16'h9999 : score_sum[15:0];

        // A coin and a game start in the same cycle cancel out.
        if (start_ok && !coinIn) begin
            credits_d = credits_q - 4'd1;
        end else if (!start_ok && coinIn && (credits_q < CRED_MAX)) begin
            credits_d = credits_q + 4'd1;
        end

        case (state_q)
            ST_STANDBY: begin
                if (start_ok) begin
                    state_d = ST_PLAY;
                    score_d = 16'h0000;
                    lives_d = LIVES_LOAD;
`ifdef EXTRA_LIFE_EN
                    bonus_used_d = 1'b0;
`endif
                end
            end
            ST_PLAY: begin
                score_d = score_hit;
`ifdef EXTRA_LIFE_EN
                // Packed BCD orders the same as the decimal value, so a plain compare works.
                if (!bonus_used_q && (score_q < BONUS_BCD) && (score_hit >= BONUS_BCD)) begin
                    bonus_used_d = 1'b1;
                    if (lives_tmp != 3'd7) begin
                        lives_tmp = lives_tmp + 3'd1;
                    end
                end
`endif
                if (invasion) begin
                    lives_tmp = 3'd0;
                end else if (playerHit && (lives_tmp != 3'd0)) begin
                    lives_tmp = lives_tmp - 3'd1;
                end
                lives_d = lives_tmp;
                if (lives_tmp == 3'd0) begin
                    state_d = ST_GAME_OVER;
                    frame_d = 8'd0;
                    high_d  = (score_hit > high_q) ? score_hit : high_q;
                end
            end
            ST_GAME_OVER: begin
                if (startOfFrame) begin
                    frame_d = frame_q + 8'd1;
                    if ((frame_q + 8'd1) >= GO_FRAMES) begin
                        state_d = ST_STANDBY;
                    end
                end
            end
            default: begin
                state_d = ST_STANDBY;
            end
        endcase

        standby_d = (state_d == ST_STANDBY);
        ended_d   = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_STANDBY;
            score_q   <= 16'h0000;
            high_q    <= 16'h0000;
            lives_q   <= 3'd0;
            credits_q <= 4'd0;
            frame_q   <= 8'd0;
            standby_q <= 1'b1;
            ended_q   <= 1'b0;
`ifdef EXTRA_LIFE_EN
            bonus_used_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            high_q    <= high_d;
            lives_q   <= lives_d;
            credits_q <= credits_d;
            frame_q   <= frame_d;
            standby_q <= standby_d;
            ended_q   <= ended_d;
`ifdef EXTRA_LIFE_EN
            bonus_used_q <= bonus_used_d;
`endif
        end
    end

    assign scoreBCD     = score_q;
    assign highScoreBCD = high_q;
    assign lives        = lives_q;
    assign credits      = credits_q;
    assign standBy      = standby_q;
    assign gameEnded    = ended_q;

endmodule

// File: tb/tb_game_score_keeper.sv
// Directed plus randomized bench for game_score_keeper, checked against an integer-arithmetic game model.
module tb_game_score_keeper;

    localparam int GOF   = 4;
    localparam int LIV   = 3;
    localparam int MAXC  = 9;
    localparam int UFO   = 100;
    localparam int BONUS = 1500;

    logic        clk = 1'b0;
    logic        resetN;
    logic        sof, ah, uh, ph, inv, coin, start;
    logic [1:0]  row;
    logic [15:0] scoreBCD, highScoreBCD;
    logic [2:0]  lives;
    logic [3:0]  credits;
    logic        standBy, gameEnded;

    int n_checks = 0;
    int n_errors = 0;

    // model: 0 standby, 1 play, 2 game over
    int m_state, m_score, m_high, m_lives, m_credits, m_frames;
    bit m_bonus;

    game_score_keeper #(.GAME_OVER_FRAMES(GOF)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .alienHit(ah), .alienRow(row),
        .ufoHit(uh), .playerHit(ph), .invasion(inv), .coinIn(coin), .startBtn(start),
        .scoreBCD(scoreBCD), .highScoreBCD(highScoreBCD), .lives(lives), .credits(credits),
        .standBy(standBy), .gameEnded(gameEnded)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("score", scoreBCD, bcd(m_score));
        check("high", highScoreBCD, bcd(m_high));
        check("lives", {13'd0, lives}, 16'(m_lives));
        check("credits", {12'd0, credits}, 16'(m_credits));
        check("standBy", {15'd0, standBy}, 16'(m_state == 0));
        check("gameEnded", {15'd0, gameEnded}, 16'(m_state == 2));
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_lives = 0; m_credits = 0; m_frames = 0; m_bonus = 0;
    endtask

    task automatic model_step(input bit i_sof, input bit i_ah, input logic [1:0] i_row, input bit i_uh,
                              input bit i_ph, input bit i_inv, input bit i_coin, input bit i_start);
        bit go;
        int pts, old, nl;
        go = (m_state == 0) && i_start && (m_credits > 0);
        if (go && !i_coin) m_credits--;
        else if (!go && i_coin && m_credits < MAXC) m_credits++;
        if (m_state == 0) begin
            if (go) begin
                m_state = 1; m_score = 0; m_lives = LIV; m_bonus = 0;
            end
        end else if (m_state == 1) begin
            pts = (i_uh ? UFO : 0) + (i_ah ? ((i_row == 2'd0) ? 10 : (i_row == 2'd1) ? 20 : 30) : 0);
            old = m_score;
            m_score = (old + pts > 9999) ? 9999 : old + pts;
            nl = m_lives;
`ifdef EXTRA_LIFE_EN
            if (!m_bonus && old < BONUS && m_score >= BONUS) begin
                m_bonus = 1;
                if (nl < 7) nl++;
            end
`endif
            if (i_inv) nl = 0;
            else if (i_ph && nl > 0) nl--;
            m_lives = nl;
            if (nl == 0) begin
                m_state = 2; m_frames = 0;
                if (m_score > m_high) m_high = m_score;
            end
        end else begin
            if (i_sof) begin
                m_frames++;
                if (m_frames >= GOF) m_state = 0;
            end
        end
    endtask

    task automatic cyc(input bit i_sof, input bit i_ah, input logic [1:0] i_row, input bit i_uh,
                       input bit i_ph, input bit i_inv, input bit i_coin, input bit i_start);
        sof = i_sof; ah = i_ah; row = i_row; uh = i_uh; ph = i_ph; inv = i_inv; coin = i_coin; start = i_start;
        model_step(i_sof, i_ah, i_row, i_uh, i_ph, i_inv, i_coin, i_start);
        @(posedge clk);
        #1;
        sof = 0; ah = 0; row = 2'd0; uh = 0; ph = 0; inv = 0; coin = 0; start = 0;
        check_all();
    endtask

    task automatic wait_standby();
        for (int i = 0; i < 20 && m_state != 0; i++) cyc(1, 0, 2'd0, 0, 0, 0, 0, 0);
        check("reach_standby", {15'd0, standBy}, 16'd1);
    endtask

    initial begin
        resetN = 1'b0;
        sof = 0; ah = 0; row = 2'd0; uh = 0; ph = 0; inv = 0; coin = 0; start = 0;
        model_reset();
        #7;
        check_all();
        #1 resetN = 1'b1;

        // coins, start, then scoring with BCD carries
        cyc(0, 0, 2'd0, 0, 0, 0, 1, 0);
        cyc(0, 0, 2'd0, 0, 0, 0, 1, 0);
        cyc(0, 0, 2'd0, 0, 0, 0, 0, 1);
        check("start_credits", {12'd0, credits}, 16'd1);
        check("start_standby", {15'd0, standBy}, 16'd0);
        cyc(0, 1, 2'd0, 0, 0, 0, 0, 0);
        check("row0", scoreBCD, 16'h0010);
        cyc(0, 1, 2'd1, 0, 0, 0, 0, 0);
        check("row1", scoreBCD, 16'h0030);
        cyc(0, 1, 2'd2, 0, 0, 0, 0, 0);
        check("row2", scoreBCD, 16'h0060);
        cyc(0, 1, 2'd2, 1, 0, 0, 0, 0);
        check("ufo_plus_alien", scoreBCD, 16'h0190);

        // climb to 9990, saturate, then lose every life
        for (int i = 0; i < 98; i++) cyc(0, 0, 2'd0, 1, 0, 0, 0, 0);
        check("score_9990", scoreBCD, 16'h9990);
        cyc(0, 0, 2'd0, 1, 0, 0, 0, 0);
        check("score_sat", scoreBCD, 16'h9999);
        for (int i = 0; i < 10 && m_state == 1; i++) cyc(0, 0, 2'd0, 0, 1, 0, 0, 0);
        check("game_over", {15'd0, gameEnded}, 16'd1);
        check("high_latched", highScoreBCD, 16'h9999);

        // ignored inputs during GAME_OVER, then frame countdown
        cyc(0, 1, 2'd2, 1, 1, 1, 0, 1);
        check("go_ignore_credits", {12'd0, credits}, 16'd1);
        for (int i = 0; i < GOF; i++) cyc(1, 0, 2'd0, 0, 0, 0, 0, 0);
        check("back_standby", {15'd0, standBy}, 16'd1);

        // credit saturation, invasion, coin+start together
        for (int i = 0; i < 12; i++) cyc(0, 0, 2'd0, 0, 0, 0, 1, 0);
        check("credit_sat", {12'd0, credits}, 16'd9);
        cyc(0, 0, 2'd0, 0, 0, 0, 1, 1);
        check("coin_and_start", {12'd0, credits}, 16'd9);
        cyc(0, 1, 2'd1, 0, 1, 1, 0, 0);
        check("invasion_lives", {13'd0, lives}, 16'd0);
        wait_standby();

        // reset in the middle of a game
        cyc(0, 0, 2'd0, 0, 0, 0, 0, 1);
        cyc(0, 1, 2'd2, 0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        #1 model_reset();
        check_all();
        #2 resetN = 1'b1;

`ifdef EXTRA_LIFE_EN
        for (int g = 0; g < 2; g++) begin
            cyc(0, 0, 2'd0, 0, 0, 0, 1, 0);
            cyc(0, 0, 2'd0, 0, 0, 0, 0, 1);
            for (int i = 0; i < 14; i++) cyc(0, 0, 2'd0, 1, 0, 0, 0, 0);
            for (int i = 0; i < 9; i++) cyc(0, 1, 2'd0, 0, 0, 0, 0, 0);
            check("bonus_pre", scoreBCD, 16'h1490);
            cyc(0, 1, 2'd0, 0, 0, 0, 0, 0);
            check("bonus_lives", {13'd0, lives}, 16'd4);
            for (int i = 0; i < 20; i++) cyc(0, 0, 2'd0, 1, 0, 0, 0, 0);
            check("bonus_once", {13'd0, lives}, 16'd4);
            cyc(0, 0, 2'd0, 0, 0, 1, 0, 0);
            wait_standby();
        end
`endif

        // randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
